// File: rtl/uart_rx_pkg.sv
// Shared UART constants and baud divider helpers, common to uart_tx and uart_rx.
package uart_rx_pkg;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clocks per bit, truncated to the 12-bit tick counter width.
  function automatic logic [11:0] calc_p(input int unsigned freq_hz, input int unsigned baud);
    return 12'(freq_hz / baud);
  endfunction

  // Half-bit count used to land on the middle of the start bit.
  function automatic logic [11:0] calc_h(input int unsigned freq_hz, input int unsigned baud);
    return calc_p(freq_hz, baud) >> 1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous pin, with selectable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic meta;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta <= RST_VAL;
      o_q  <= RST_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, ready/done handshake, sticky framing-error
// and overrun flags.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned FREQ_HZ   = 25_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  input  logic       i_done,
  output logic [7:0] o_data,
  output logic       o_rdy,
  output logic       o_frame_err,
  output logic       o_overrun
);
  localparam logic [11:0] P        = calc_p(FREQ_HZ, BAUD_RATE);
  localparam logic [11:0] H        = calc_h(FREQ_HZ, BAUD_RATE);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state;
  logic [11:0] tick;
  logic [2:0]  bitcnt;
  logic [7:0]  shreg;
  logic        byte_done;
  logic        rxs;
  logic        stop_smp;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rxd),
    .o_q   (rxs)
  );

  assign stop_smp = (state == STOP) && (tick == P - 12'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      tick        <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      byte_done   <= 1'b0;
      o_data      <= '0;
      o_rdy       <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      tick      <= tick + 12'd1;
      case (state)
        IDLE: if (!rxs) begin
          state <= START;
          tick  <= '0;
        end
        START: if (tick == H - 12'd1) begin
          tick   <= '0;
          bitcnt <= '0;
          state  <= rxs ? IDLE : DATA;
        end
        DATA: if (tick == P - 12'd1) begin
          tick   <= '0;
          shreg  <= {rxs, shreg[7:1]};
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == LAST_BIT) state <= STOP;
        end
        STOP: if (stop_smp) begin
          tick <= '0;
          if (rxs) begin
            byte_done <= 1'b1;
            state     <= IDLE;
          end else begin
            state <= BREAK;
          end
        end
        // Held-low line must return high before a new start is looked for.
        BREAK: if (rxs) begin
          state <= IDLE;
          tick  <= '0;
        end
        default: begin
          state <= IDLE;
          tick  <= '0;
        end
      endcase

      // A completing byte beats a simultaneous i_done for o_rdy.
      if (byte_done)   begin
        o_data <= shreg;
        o_rdy  <= 1'b1;
      end else if (i_done) begin
        o_rdy  <= 1'b0;
      end
      o_overrun <= !i_done && (o_overrun || (byte_done && o_rdy));

      if (stop_smp && !rxs) o_frame_err <= 1'b1;
      else if (i_done)      o_frame_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;
  localparam int unsigned FREQ = 1_000_000;
  localparam int unsigned BAUD = 100_000;
  localparam int P   = FREQ / BAUD;
  localparam int H   = P / 2;
  // start edge to o_rdy: 2 sync + 1 detect + H + 9P to stop sample + 1 load
  localparam int LAT = 2 + 1 + H + 9 * P + 1;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rxd = 1'b1;
  logic       i_done = 1'b0;
  logic [7:0] o_data;
  logic       o_rdy, o_frame_err, o_overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cyc = -1;
  int done_off = -1;
  int t_start = 0;
  int rise_cyc = -1;
  int rdy_rises = 0;
  int ferr_rises = 0;
  logic rdy_q = 1'b0;
  logic ferr_q = 1'b0;

  uart_rx #(.FREQ_HZ(FREQ), .BAUD_RATE(BAUD)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rxd       (i_rxd),
    .i_done      (i_done),
    .o_data      (o_data),
    .o_rdy       (o_rdy),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Event recorder only; all comparisons live in the main sequence.
  always @(negedge i_clk) begin
    if (o_rdy && !rdy_q) begin
      rise_cyc  = cyc;
      rdy_rises = rdy_rises + 1;
    end
    if (o_frame_err && !ferr_q) ferr_rises = ferr_rises + 1;
    rdy_q  = o_rdy;
    ferr_q = o_frame_err;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    i_done = (cyc == done_cyc);
  endtask

  task automatic pulse_done();
    done_cyc = cyc + 1;
    step();
    step();
  endtask

  task automatic hold(input logic v, input int n);
    i_rxd = v;
    repeat (n) step();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    step();
    t_start = cyc;
    if (done_off >= 0) done_cyc = t_start + done_off;
    hold(1'b0, P - 1);
    for (int k = 0; k < 8; k++) begin
      step();
      hold(b[k], P - 1);
    end
    step();
    hold(stop_v, P - 1);
  endtask

  logic [7:0] rb;
  logic       exp_rdy, exp_ovr;
  int         gap, saved;

  initial begin
    repeat (3) step();
    chk("reset_data", o_data, 8'h00);
    chk("reset_rdy", o_rdy, 1'b0);
    chk("reset_ferr", o_frame_err, 1'b0);
    chk("reset_ovr", o_overrun, 1'b0);
    i_rst = 1'b0;
    repeat (5) step();

    // 1: basic frame and latency
    send_frame(8'h55, 1'b1);
    step();
    chk("t1_latency", rise_cyc - t_start, LAT);
    chk("t1_data", o_data, 8'h55);
    chk("t1_rdy", o_rdy, 1'b1);
    chk("t1_ferr", o_frame_err, 1'b0);
    chk("t1_ovr", o_overrun, 1'b0);
    step();
    pulse_done();
    chk("t1_rdy_clr", o_rdy, 1'b0);

    // 2: short low glitch must not start a frame
    saved = rdy_rises;
    step();
    hold(1'b0, 3);
    hold(1'b1, 20);
    chk("t2_glitch_rises", rdy_rises, saved);
    chk("t2_glitch_ferr", o_frame_err, 1'b0);
    send_frame(8'hA3, 1'b1);
    step();
    chk("t2_data", o_data, 8'hA3);
    chk("t2_rdy", o_rdy, 1'b1);
    pulse_done();

    // 3: framing error with break hold, then recovery
    saved = rdy_rises;
    send_frame(8'h00, 1'b0);
    hold(1'b0, 30);
    chk("t3_ferr", o_frame_err, 1'b1);
    chk("t3_rdy", o_rdy, 1'b0);
    chk("t3_no_retrigger", rdy_rises, saved);
    chk("t3_ferr_rises", ferr_rises, 1);
    hold(1'b1, 10);
    send_frame(8'h3C, 1'b1);
    step();
    chk("t3_data", o_data, 8'h3C);
    chk("t3_rdy2", o_rdy, 1'b1);
    chk("t3_ferr_sticky", o_frame_err, 1'b1);
    pulse_done();
    chk("t3_ferr_clr", o_frame_err, 1'b0);
    chk("t3_rdy_clr", o_rdy, 1'b0);

    // 4: overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    step();
    chk("t4_data", o_data, 8'h22);
    chk("t4_rdy", o_rdy, 1'b1);
    chk("t4_ovr", o_overrun, 1'b1);
    pulse_done();
    chk("t4_rdy_clr", o_rdy, 1'b0);
    chk("t4_ovr_clr", o_overrun, 1'b0);

    // random frames against a ready/overrun model
    exp_rdy = 1'b0;
    exp_ovr = 1'b0;
    for (int n = 0; n < 10; n++) begin
      rb  = 8'($urandom);
      gap = $urandom_range(0, 15);
      send_frame(rb, 1'b1);
      step();
      hold(1'b1, gap);
      exp_ovr = exp_ovr | exp_rdy;
      exp_rdy = 1'b1;
      chk("rnd_data", o_data, rb);
      chk("rnd_rdy", o_rdy, exp_rdy);
      chk("rnd_ovr", o_overrun, exp_ovr);
      if ($urandom_range(0, 1) == 1) begin
        pulse_done();
        exp_rdy = 1'b0;
        exp_ovr = 1'b0;
        chk("rnd_rdy_clr", o_rdy, 1'b0);
      end
    end

    // 5: reset mid-frame; leave a byte pending so reset has something to clear
    send_frame(8'h5A, 1'b1);
    step();
    rb = 8'h99;
    step();
    hold(1'b0, P - 1);
    for (int k = 0; k < 3; k++) begin
      step();
      hold(rb[k], P - 1);
    end
    step();
    hold(rb[3], 4);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    saved = rdy_rises;
    hold(rb[3], 4);
    hold(1'b1, 30);
    chk("t5_data", o_data, 8'h00);
    chk("t5_rdy", o_rdy, 1'b0);
    chk("t5_ferr", o_frame_err, 1'b0);
    chk("t5_ovr", o_overrun, 1'b0);
    chk("t5_no_delivery", rdy_rises, saved);
    send_frame(8'hF0, 1'b1);
    step();
    chk("t5_data2", o_data, 8'hF0);
    chk("t5_rdy2", o_rdy, 1'b1);
    chk("t5_ferr2", o_frame_err, 1'b0);
    pulse_done();

    // 6: back-to-back, i_done on the second completion cycle
    send_frame(8'h01, 1'b1);
    done_off = LAT - 1;
    send_frame(8'h80, 1'b1);
    done_off = -1;
    step();
    step();
    chk("t6_data", o_data, 8'h80);
    chk("t6_rdy", o_rdy, 1'b1);
    chk("t6_ovr", o_overrun, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
